// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W        = 64;
  localparam int BYTE_OFFSET_W = 3;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake between the datapath (master) and the memory responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with WAIT_CYCLES wait states and registered response.
// Optional address fault checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             reset_n,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               lat_write;
  logic [WORD_W-1:0]  lat_addr;
  logic [WORD_W-1:0]  lat_wdata;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [WORD_W-1:0]  rsp_rdata_q;

  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  rd_word;
  logic               addr_err;
  logic               commit;
  logic               mem_we;

  assign idx = lat_addr[BYTE_OFFSET_W +: IDX_W];

`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_err = (lat_addr[BYTE_OFFSET_W-1:0] != '0) ||
                    (lat_addr[WORD_W-1:BYTE_OFFSET_W+IDX_W] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lat_addr[BYTE_OFFSET_W-1:0], lat_addr[WORD_W-1:BYTE_OFFSET_W+IDX_W]};
  assign addr_err = 1'b0;
`endif

  // The last WAIT edge both commits the store and captures the load word.
  assign commit = (state == S_WAIT) && (cnt == '0);
  assign mem_we = commit && lat_write && !addr_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (idx),
    .wdata (lat_wdata),
    .raddr (idx),
    .rdata (rd_word)
  );

  // WAIT always spans WAIT_CYCLES+1 edges so the response appears WAIT_CYCLES+1 edges after acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ready_q && bus.req_valid) begin
            lat_write   <= bus.req_write;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            cnt         <= CNT_W'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            state       <= S_WAIT;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= addr_err;
            rsp_rdata_q <= (lat_write || addr_err) ? '0 : rd_word;
            state       <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
